// File: rtl/rca_share_arb.sv
// Two-port arbiter sharing one 32-bit ripple-carry adder; multi-word transactions
// lock the adder to one requester and chain the carry between words.

module RCA32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic [32:0] w_c;

    assign w_c[0] = cin;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_fa
            assign s[gi]     = a[gi] ^ b[gi] ^ w_c[gi];
            assign w_c[gi+1] = (a[gi] & b[gi]) | (w_c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_c[32];
endmodule

module rca_share_arb #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req0_cin,
    input  logic        req0_last,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic        req1_cin,
    input  logic        req1_last,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_sum,
    output logic        rsp_cout,
    output logic        rsp_id,
    output logic        rsp_last
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_carry;
    logic        r_rr_prev;   // port of the last completed transaction
    logic        r_rsp_valid;
    logic [31:0] r_rsp_sum;
    logic        r_rsp_cout;
    logic        r_rsp_id;
    logic        r_rsp_last;

    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_space;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_acc;
    logic        w_sel;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic        w_cin;
    logic        w_last;
    logic [31:0] w_sum;
    logic        w_cout;

    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        case (r_state)
            IDLE: begin
                // r_rr_prev=1 means port 1 went last, so port 0 is preferred
                if (req0_valid && (!req1_valid || PRIO_FIXED || r_rr_prev))
                    w_gnt0 = 1'b1;
                else if (req1_valid)
                    w_gnt1 = 1'b1;
            end
            LOCK0:   w_gnt0 = 1'b1;
            LOCK1:   w_gnt1 = 1'b1;
            default: ;
        endcase
    end

    // Only the registered rsp_valid gates acceptance, never the next result.
    assign w_space    = !r_rsp_valid || rsp_ready;
    assign req0_ready = rst && w_gnt0 && w_space;
    assign req1_ready = rst && w_gnt1 && w_space;

    assign w_acc0 = req0_valid && req0_ready;
    assign w_acc1 = req1_valid && req1_ready;
    assign w_acc  = w_acc0 || w_acc1;
    assign w_sel  = w_acc1;

    assign w_a    = w_sel ? req1_a    : req0_a;
    assign w_b    = w_sel ? req1_b    : req0_b;
    assign w_last = w_sel ? req1_last : req0_last;
    assign w_cin  = (r_state == IDLE) ? (w_sel ? req1_cin : req0_cin) : r_carry;

    RCA32 u_rca (
        .s    (w_sum),
        .cout (w_cout),
        .a    (w_a),
        .b    (w_b),
        .cin  (w_cin)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_carry     <= 1'b0;
            r_rr_prev   <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= 32'd0;
            r_rsp_cout  <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else if (w_acc) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_cout  <= w_cout;
            r_rsp_id    <= w_sel;
            r_rsp_last  <= w_last;
            r_carry     <= w_cout;
            if (w_last) begin
                r_state   <= IDLE;
                r_rr_prev <= w_sel;
            end else begin
                r_state   <= w_sel ? LOCK1 : LOCK0;
            end
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_cout  = r_rsp_cout;
    assign rsp_id    = r_rsp_id;
    assign rsp_last  = r_rsp_last;
endmodule

// File: tb/tb_rca_share_arb.sv
// Directed scoreboard bench for rca_share_arb: expectations queued at issue time,
// a negedge monitor pops them on every response handshake.

module tb_rca_share_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_cin, req0_last;
    logic        req1_valid, req1_cin, req1_last;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp_ready;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_cout, rsp_id, rsp_last;
    logic [31:0] rsp_sum;
    logic        fx_req0_ready, fx_req1_ready;
    logic        fx_rsp_valid, fx_rsp_cout, fx_rsp_id, fx_rsp_last;
    logic [31:0] fx_rsp_sum;

    int total = 0;
    int bad   = 0;
    logic [34:0] q[$];
    logic [34:0] m_exp;

    always #5 clk = ~clk;

    rca_share_arb #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_last(req1_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout), .rsp_id(rsp_id), .rsp_last(rsp_last)
    );

    rca_share_arb #(.PRIO_FIXED(1'b1)) dut_fx (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_last(req0_last),
        .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_last(req1_last),
        .rsp_valid(fx_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(fx_rsp_sum),
        .rsp_cout(fx_rsp_cout), .rsp_id(fx_rsp_id), .rsp_last(fx_rsp_last)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void push(input logic [31:0] s, input logic c, input logic id, input logic l);
        q.push_back({s, c, id, l});
    endfunction

    task automatic drv0(input logic [31:0] a, input logic [31:0] b, input logic c, input logic l);
        req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = c; req0_last = l;
    endtask

    task automatic drv1(input logic [31:0] a, input logic [31:0] b, input logic c, input logic l);
        req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = c; req1_last = l;
    endtask

    always @(negedge clk) begin
        if (rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp act=%h exp=none", {rsp_sum, rsp_cout, rsp_id, rsp_last});
            end else begin
                m_exp = q.pop_front();
                chk("rsp", {29'd0, rsp_sum, rsp_cout, rsp_id, rsp_last}, {29'd0, m_exp});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_last = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_last = 1'b0;

        // reset: ready held low even with valid requests
        drv0(32'h1, 32'h1, 1'b0, 1'b1);
        drv1(32'h1, 32'h1, 1'b0, 1'b1);
        step(); step();
        @(negedge clk);
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_rsp", {29'd0, rsp_valid, rsp_sum, rsp_cout, rsp_id, rsp_last}, 64'd0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b1;

        // single word with carry out
        step();
        drv0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1); push(32'h0, 1'b1, 1'b0, 1'b1);
        @(negedge clk); chk("single_ready0", {63'd0, req0_ready}, 64'd1);
        step(); req0_valid = 1'b0;
        @(negedge clk); chk("single_latency", {63'd0, rsp_valid}, 64'd1);

        // two-word chain on port 1; second word's cin must be ignored
        step();
        drv1(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); push(32'h0, 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk("chain_ready_w0", {63'd0, req1_ready}, 64'd1);
        step();
        drv1(32'h0, 32'h0, 1'b1, 1'b1); push(32'h1, 1'b0, 1'b1, 1'b1);
        @(negedge clk); chk("chain_ready_w1", {63'd0, req1_ready}, 64'd1);
        step(); req1_valid = 1'b0;

        // contention after reset: RR alternates, fixed priority always port 0
        step(); rst = 1'b0;
        step(); step(); rst = 1'b1;
        drv0(32'd10, 32'd1, 1'b0, 1'b1);
        drv1(32'd20, 32'd2, 1'b0, 1'b1);
        push(32'd11, 1'b0, 1'b0, 1'b1); push(32'd22, 1'b0, 1'b1, 1'b1);
        push(32'd11, 1'b0, 1'b0, 1'b1); push(32'd22, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rr_ready0_%0d", i), {63'd0, req0_ready}, {63'd0, (i % 2 == 0)});
            chk($sformatf("rr_ready1_%0d", i), {63'd0, req1_ready}, {63'd0, (i % 2 == 1)});
            chk($sformatf("fx_ready_%0d", i), {62'd0, fx_req0_ready, fx_req1_ready}, 64'd2);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); chk("fx_rsp", {30'd0, fx_rsp_sum, fx_rsp_id, fx_rsp_last}, {30'd0, 32'd11, 1'b0, 1'b1});

        // lock: port 0 three words while port 1 waits
        step();
        drv0(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0); push(32'h0, 1'b1, 1'b0, 1'b0);
        drv1(32'd5, 32'd6, 1'b0, 1'b1);
        @(negedge clk);
        chk("lock_ready0", {63'd0, req0_ready}, 64'd1);
        chk("lock_ready1_w0", {63'd0, req1_ready}, 64'd0);
        step();
        drv0(32'h1, 32'h1, 1'b0, 1'b0); push(32'h3, 1'b0, 1'b0, 1'b0);
        @(negedge clk); chk("lock_ready1_w1", {63'd0, req1_ready}, 64'd0);
        step();
        drv0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1); push(32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1);
        @(negedge clk); chk("lock_ready1_w2", {63'd0, req1_ready}, 64'd0);
        step();
        req0_valid = 1'b0; push(32'd11, 1'b0, 1'b1, 1'b1);
        @(negedge clk); chk("lock_release", {63'd0, req1_ready}, 64'd1);
        step(); req1_valid = 1'b0;

        // lock held through gaps with carry preserved
        step();
        drv0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); push(32'h0, 1'b1, 1'b0, 1'b0);
        step();
        req0_valid = 1'b0; drv1(32'd5, 32'd6, 1'b0, 1'b1);
        @(negedge clk); chk("hold_ready1_a", {63'd0, req1_ready}, 64'd0);
        step();
        @(negedge clk); chk("hold_ready1_b", {63'd0, req1_ready}, 64'd0);
        step();
        drv0(32'h0, 32'h0, 1'b0, 1'b1); push(32'h1, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("hold_ready0", {63'd0, req0_ready}, 64'd1);
        step();
        req0_valid = 1'b0; push(32'd11, 1'b0, 1'b1, 1'b1);
        @(negedge clk); chk("hold_next1", {63'd0, req1_ready}, 64'd1);
        step(); req1_valid = 1'b0;

        // backpressure: 3 stalled cycles, then one word per cycle
        step();
        drv0(32'd100, 32'd0, 1'b0, 1'b1); push(32'd100, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("bp_ready_w0", {63'd0, req0_ready}, 64'd1);
        step();
        req0_b = 32'd1; rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_stall_%0d", i), {30'd0, req0_ready, rsp_valid, rsp_sum},
                {30'd0, 1'b0, 1'b1, 32'd100});
            step();
        end
        rsp_ready = 1'b1; push(32'd101, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("bp_resume_1", {63'd0, req0_ready}, 64'd1);
        step();
        req0_b = 32'd2; push(32'd102, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("bp_resume_2", {63'd0, req0_ready}, 64'd1);
        step();
        req0_b = 32'd3; push(32'd103, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("bp_resume_3", {63'd0, req0_ready}, 64'd1);
        step(); req0_valid = 1'b0;
        step();

        // reset mid-lock with a pending result: result dropped, carry cleared
        step();
        drv0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0); rsp_ready = 1'b0;
        step();
        req0_valid = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1; rsp_ready = 1'b1;
        @(negedge clk); chk("rst_mid_valid", {63'd0, rsp_valid}, 64'd0);
        step();
        drv0(32'h1, 32'h1, 1'b0, 1'b1); push(32'h2, 1'b0, 1'b0, 1'b1);
        @(negedge clk); chk("rst_mid_ready0", {63'd0, req0_ready}, 64'd1);
        step(); req0_valid = 1'b0;

        for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        chk("drain", {32'd0, q.size()}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rca_share_arb.md
RCA_SHARE_ARB -- requirements
Module: rca_share_arb

Interface
REQ-001 SHALL have parameter: PRIO_FIXED, 0, arbitration mode (0 = round-robin, 1 = fixed priority to port 0).
REQ-002 SHALL have port: clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: reqN_valid  input  1  requester N word valid (N = 0, 1).
REQ-005 SHALL have ports: reqN_ready  output  1  word accepted from requester N this cycle when valid and ready are both high.
REQ-006 SHALL have ports: reqN_a, reqN_b  input  32  operand words.
REQ-007 SHALL have ports: reqN_cin  input  1  carry-in, used on the first word of a transaction only.
REQ-008 SHALL have ports: reqN_last  input  1  final word of a multi-word transaction.
REQ-009 SHALL have port: rsp_valid  output  1  result register holds a valid word.
REQ-010 SHALL have port: rsp_ready  input  1  consumer accepts the result.
REQ-011 SHALL have ports: rsp_sum  output  32 sum; rsp_cout  output  1  carry-out; rsp_id  output  1  source port; rsp_last  output  1  copy of the accepted word's last flag.

Function
REQ-012 SHALL instantiate one RCA32 (ports s, cout, a, b, cin) as the only adder, shared by both ports.
REQ-013 SHALL implement an FSM with states IDLE, LOCK0 and LOCK1.
REQ-014 In IDLE, the grant SHALL be combinational over the valid requests: if one port is valid, that port wins; if both are valid, PRIO_FIXED=1 selects port 0, and PRIO_FIXED=0 selects the port not granted in the last completed transaction.
REQ-015 In LOCKx, the grant SHALL go only to port x; the other port's ready SHALL be 0.
REQ-016 reqN_ready SHALL equal grantN AND (NOT rsp_valid OR rsp_ready).
REQ-017 reqN_ready SHALL NOT depend combinationally on rsp_valid of the same cycle's new result, only on the registered rsp_valid.
REQ-018 On accept in IDLE, the adder carry-in SHALL be reqN_cin.
REQ-019 On accept in LOCKx, the adder carry-in SHALL be the stored carry register, and reqN_cin SHALL be ignored.
REQ-020 On every accept, the carry register SHALL load the adder cout.
REQ-021 On accept, rsp_sum, rsp_cout, rsp_id and rsp_last SHALL be registered, and rsp_valid SHALL be 1 on the next cycle (latency 1).
REQ-022 On accept with last=0, the FSM SHALL go to or stay in LOCKx.
REQ-023 On accept with last=1, the FSM SHALL return to IDLE and the round-robin pointer SHALL record x.
REQ-024 rsp_valid AND rsp_ready with no new accept SHALL clear rsp_valid.
REQ-025 rsp_valid AND rsp_ready with a simultaneous accept SHALL keep rsp_valid=1 and load the new word (full throughput, one word per cycle).
REQ-026 While rsp_valid=1 and rsp_ready=0, all rsp_* outputs SHALL hold stable and no word SHALL be accepted.
REQ-027 In LOCKx with reqx_valid=0, the FSM SHALL hold LOCKx indefinitely with the carry preserved.
REQ-028 Arithmetic SHALL be modulo 2^32 per word, with rsp_cout equal to bit 32 of a+b+cin.

Reset
REQ-029 When rst=0 at a clock edge, the state SHALL become IDLE, the round-robin pointer SHALL be set to prefer port 0, and the carry register SHALL be 0.
REQ-030 When rst=0 at a clock edge, rsp_valid, rsp_sum, rsp_cout, rsp_id and rsp_last SHALL be 0.
REQ-031 While rst=0, reqN_ready SHALL be 0.
REQ-032 Reset during LOCKx or with a pending result SHALL abort the transaction and drop the result; no partial state SHALL survive.

Verification
REQ-033 Single word: port0 a=FFFFFFFF, b=00000001, cin=0, last=1 -> next cycle rsp_valid=1, sum=00000000, cout=1, id=0, last=1.
REQ-034 Two-word chain: port1 word0 FFFFFFFF+00000001 (cin=0, last=0), then word1 00000000+00000000 (cin=1, last=1) -> responses 00000000/cout1/last0, then 00000001/cout0/last1, id=1; the word1 cin is ignored.
REQ-035 Contention with PRIO_FIXED=0 and both ports streaming single-word requests after reset -> grants alternate 0,1,0,1; with PRIO_FIXED=1, all four grants go to port 0.
REQ-036 Lock: port0 three-word transaction while port1 holds valid -> req1_ready=0 until port0's last word is accepted, then port1 is granted the next cycle.
REQ-037 Backpressure: rsp_ready=0 for 3 cycles with a result pending -> rsp_* stable, req ready=0, no word lost or duplicated; then one word per cycle resumes.
REQ-038 Reset mid-LOCK0 with rsp_valid=1 -> next cycle rsp_valid=0, state IDLE; a new port0 word with cin=0 computes with carry 0.
